serial_adder_controller: RTL and testbench

//  - Bit-serial N-bit add/subtract engine built around one full_adder_using_half_adder instance.
//  - FSM + shift registers + carry flop feed the 1-bit adder LSB-first, one bit per clock.
//  - Request/response handshake so a host can issue operations without a wide parallel adder.

---
 rtl/serial_adder_controller.sv | 153 +++++++++++++++
 tb/tb_serial_adder_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_controller.sv
// Bit-serial WIDTH-bit add/subtract engine: operands are shifted LSB-first through a
// single full adder, with a start/done valid-ready handshake to the host.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder_using_half_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

  assign cout = c1 | c2;
endmodule

module serial_adder_controller #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic             fa_sum, fa_cout;
  logic             accept, last_bit;

  full_adder_using_half_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign res_nxt = {fa_sum, res_sr[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid && start_ready) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        last_bit = (bit_cnt == LAST_BIT);
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags track the state being entered so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
    end else begin
      start_ready <= (state_d == IDLE);
      busy        <= (state_d == RUN);
      done_valid  <= (state_d == DONE);
    end
  end

  // Serial datapath; subtract is A + ~B + 1 with the +1 seeded into the carry flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      bit_cnt   <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_sr    <= op_a;
      b_sr    <= sub ? ~op_b : op_b;
      carry   <= sub;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      carry  <= fa_cout;
      if (last_bit) begin
        result    <= res_nxt;
        carry_out <= fa_cout;
        overflow  <= carry ^ fa_cout;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_controller.sv
// Self-checking bench for serial_adder_controller (WIDTH=8): directed vectors,
// backpressure / ignored-start / mid-run reset sequences, and random ops vs a model.

module tb_serial_adder_controller;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a, op_b;
  logic         sub;
  logic         busy;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_controller #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic co, output logic ov);
    int ua, ub, sa, sb, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - 256 : ua;
    sb = b[W-1] ? ub - 256 : ub;
    if (s) begin
      r  = W'(ua - ub);
      co = (ua >= ub);
      v  = sa - sb;
    end else begin
      r  = W'(ua + ub);
      co = (ua + ub) > 255;
      v  = sa + sb;
    end
    ov = (v > 127) || (v < -128);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    while (!start_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_ready", 32'(start_ready), 32'd1);
    op_a        = a;
    op_b        = b;
    sub         = s;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_valid && n < 40) begin
      step();
      n++;
    end
    chk("done_seen", 32'(done_valid), 32'd1);
  endtask

  task automatic release_done();
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  vec_t         vecs[5];
  int           n;
  logic [W-1:0] er;
  logic         eco, eov;
  logic [W-1:0] ra, rb;
  logic         rs;
  int           dly;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{a: 8'h35, b: 8'h4A, s: 1'b0, r: 8'h7F, co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 1'b0, r: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, s: 1'b0, r: 8'h80, co: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 8'h10, b: 8'h20, s: 1'b1, r: 8'hF0, co: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, s: 1'b1, r: 8'h7F, co: 1'b1, ov: 1'b1};

    rst_n       = 1'b0;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    op_a        = '0;
    op_b        = '0;
    sub         = 1'b0;
    #12;
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_busy",        32'(busy),        32'd0);
    chk("rst_done_valid",  32'(done_valid),  32'd0);
    chk("rst_result",      32'(result),      32'd0);
    chk("rst_carry_out",   32'(carry_out),   32'd0);
    chk("rst_overflow",    32'(overflow),    32'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors, including latency from accept to done
    for (int i = 0; i < 5; i++) begin
      accept_op(vecs[i].a, vecs[i].b, vecs[i].s);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_start_ready", 32'(start_ready), 32'd0);
      wait_done(n);
      chk("latency", 32'(n), 32'(W));
      chk("vec_result",    32'(result),    32'(vecs[i].r));
      chk("vec_carry_out", 32'(carry_out), 32'(vecs[i].co));
      chk("vec_overflow",  32'(overflow),  32'(vecs[i].ov));
      release_done();
      chk("idle_ready", 32'(start_ready), 32'd1);
      chk("idle_done_valid", 32'(done_valid), 32'd0);
      chk("idle_result_kept", 32'(result), 32'(vecs[i].r));
    end

    // Backpressure with start_valid noise during RUN and DONE
    accept_op(8'h35, 8'h4A, 1'b0);
    op_a        = 8'hC3;
    op_b        = 8'h99;
    sub         = 1'b1;
    start_valid = 1'b1;
    wait_done(n);
    chk("bp_latency", 32'(n), 32'(W));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_done_held", 32'(done_valid), 32'd1);
      chk("bp_result_held", 32'(result), 32'h7F);
      chk("bp_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    release_done();
    chk("bp_idle", 32'(start_ready), 32'd1);
    chk("bp_result_after", 32'(result), 32'h7F);

    // done_ready in IDLE has no effect
    done_ready = 1'b1;
    step();
    step();
    done_ready = 1'b0;
    chk("idle_done_ready_ignored", 32'(start_ready), 32'd1);

    // Asynchronous reset mid-RUN after 3 bits
    accept_op(8'hAA, 8'h11, 1'b0);
    step();
    step();
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",        32'(busy),        32'd0);
    chk("mid_rst_start_ready", 32'(start_ready), 32'd1);
    chk("mid_rst_done_valid",  32'(done_valid),  32'd0);
    chk("mid_rst_result",      32'(result),      32'd0);
    chk("mid_rst_carry_out",   32'(carry_out),   32'd0);
    chk("mid_rst_overflow",    32'(overflow),    32'd0);
    #6;
    rst_n = 1'b1;
    step();
    accept_op(8'h01, 8'h01, 1'b0);
    wait_done(n);
    chk("post_rst_latency", 32'(n), 32'(W));
    chk("post_rst_result", 32'(result), 32'h02);
    chk("post_rst_carry_out", 32'(carry_out), 32'd0);
    chk("post_rst_overflow", 32'(overflow), 32'd0);
    release_done();

    // Random operations vs reference model
    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rs  = 1'($urandom);
      dly = int'($urandom_range(0, 3));
      model(ra, rb, rs, er, eco, eov);
      accept_op(ra, rb, rs);
      wait_done(n);
      chk("rnd_latency", 32'(n), 32'(W));
      for (int d = 0; d < dly; d++) step();
      chk("rnd_result",    32'(result),    32'(er));
      chk("rnd_carry_out", 32'(carry_out), 32'(eco));
      chk("rnd_overflow",  32'(overflow),  32'(eov));
      release_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
